// File: rtl/ysyx_25040109_wbu.sv
// ----------------------------------------------------------------------------
// ysyx_25040109_wbu -- write-back stage
//
// Holds one retiring instruction taken from the LSU and walks it through two
// phases:
//   WRITE  : one cycle in which the GPR file write port is driven
//   COMMIT : the next PC is offered to the IFU until it is accepted; on that
//            handshake the retire/fault counters move and, for a bus error,
//            an access-fault trap pulse is raised
// A bus response error replaces the write with an access fault that redirects
// the fetch to TRAP_VEC.
//
// Ports
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready          handshake from the LSU
//   in_pc, in_next_pc, in_rd,
//   in_rd_wen, in_is_load,
//   in_alu_res, in_load_data,
//   in_mem_addr, in_resp_err     instruction bundle
//   rf_wen, rf_waddr, rf_wdata   GPR write port (single-cycle pulse)
//   pc_valid / pc_ready, pc_next next-PC handshake towards the IFU
//   trap_valid, trap_epc,
//   trap_tval                    access-fault event, coincident with commit
//   retire_cnt, fault_cnt        free-running wrap-around counters
// ----------------------------------------------------------------------------
module ysyx_25040109_wbu #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   TRAP_VEC = 32'h8000_0100,
  parameter int                CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_next_pc,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wen,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_load_data,
  input  logic [XLEN-1:0]   in_mem_addr,
  input  logic              in_resp_err,

  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,

  output logic              pc_valid,
  input  logic              pc_ready,
  output logic [XLEN-1:0]   pc_next,

  output logic              trap_valid,
  output logic [XLEN-1:0]   trap_epc,
  output logic [XLEN-1:0]   trap_tval,

  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  fault_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Stage register contents. Only fields needed downstream are kept; the
  // write data is resolved at capture time so WRITE needs no mux.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] mem_addr;
    logic            resp_err;
  } stage_t;

  state_e            state_q, state_d;
  stage_t            stage_q, stage_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

  logic              accept;
  logic              commit_fire;
  logic              in_write;
  logic              in_commit;

  assign in_write    = (state_q == ST_WRITE);
  assign in_commit   = (state_q == ST_COMMIT);
  assign in_ready    = (state_q == ST_EMPTY);
  assign accept      = in_valid && in_ready;
  assign commit_fire = in_commit && pc_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY:  if (accept) state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_COMMIT;
      ST_COMMIT: if (pc_ready) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;   // recover from an unused encoding
    endcase
  end

  // Stage capture. The register is never cleared: every consumer is
  // qualified by the state, so stale contents are harmless.
  always_comb begin
    stage_d = stage_q;
    if (accept) begin
      stage_d.pc       = in_pc;
      stage_d.next_pc  = in_next_pc;
      stage_d.rd       = in_rd;
      stage_d.rd_wen   = in_rd_wen;
      stage_d.wdata    = in_is_load ? in_load_data : in_alu_res;
      stage_d.mem_addr = in_mem_addr;
      stage_d.resp_err = in_resp_err;
    end
  end

  // Counters advance only on the commit handshake; exactly one of them moves.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    fault_cnt_d  = fault_cnt_q;
    if (commit_fire) begin
      if (stage_q.resp_err) fault_cnt_d  = fault_cnt_q + CNT_W'(1);
      else                  retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State and counter flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      retire_cnt_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    stage_q <= stage_d;
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the state flop so an asynchronous reset silences
  // them immediately.
  // --------------------------------------------------------------------------
  assign rf_wen   = in_write && stage_q.rd_wen && (stage_q.rd != 5'd0) && !stage_q.resp_err;
  assign rf_waddr = in_write ? stage_q.rd    : 5'd0;
  assign rf_wdata = in_write ? stage_q.wdata : '0;

  assign pc_valid = in_commit;
  assign pc_next  = !in_commit        ? '0       :
                    stage_q.resp_err  ? TRAP_VEC : stage_q.next_pc;

  // The trap pulse is tied to the commit handshake itself, not to COMMIT,
  // so a stalled IFU cannot produce repeated trap events.
  assign trap_valid = commit_fire && stage_q.resp_err;
  assign trap_epc   = trap_valid ? stage_q.pc       : '0;
  assign trap_tval  = trap_valid ? stage_q.mem_addr : '0;

  assign retire_cnt = retire_cnt_q;
  assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_ysyx_25040109_wbu.sv
module tb_ysyx_25040109_wbu;

  localparam logic [31:0] TRAP_VEC = 32'h8000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_next_pc, in_alu_res, in_load_data, in_mem_addr;
  logic [4:0]  in_rd;
  logic        in_rd_wen, in_is_load, in_resp_err;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_valid, pc_ready;
  logic [31:0] pc_next;
  logic        trap_valid;
  logic [31:0] trap_epc, trap_tval;
  logic [31:0] retire_cnt, fault_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected counter values.
  int unsigned m_retire = 0;
  int unsigned m_fault  = 0;

  always #5 clock = ~clock;

  ysyx_25040109_wbu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_next_pc(in_next_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_is_load(in_is_load), .in_alu_res(in_alu_res), .in_load_data(in_load_data),
    .in_mem_addr(in_mem_addr), .in_resp_err(in_resp_err),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_next(pc_next),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .retire_cnt(retire_cnt), .fault_cnt(fault_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    in_pc        = $urandom;
    in_next_pc   = $urandom;
    in_rd        = 5'($urandom);
    in_rd_wen    = 1'($urandom);
    in_is_load   = 1'($urandom);
    in_alu_res   = $urandom;
    in_load_data = $urandom;
    in_mem_addr  = $urandom;
    in_resp_err  = 1'($urandom);
  endtask

  // One complete instruction; called at a negedge with the stage empty and
  // returns at a negedge with the stage empty again.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] npc,
                           input logic [4:0] rd, input logic wen, input logic ld,
                           input logic [31:0] alu, input logic [31:0] ldd,
                           input logic [31:0] addr, input logic err, input int stall);
    logic        exp_wen;
    logic [31:0] exp_data, exp_next;
    int          waited;
    exp_wen  = wen && (rd != 5'd0) && !err;
    exp_data = ld ? ldd : alu;
    exp_next = err ? TRAP_VEC : npc;

    in_pc = pc; in_next_pc = npc; in_rd = rd; in_rd_wen = wen; in_is_load = ld;
    in_alu_res = alu; in_load_data = ldd; in_mem_addr = addr; in_resp_err = err;
    in_valid = 1'b1; pc_ready = 1'b0;
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    scramble_inputs();   // the stage must hold its own copy

    @(negedge clock);    // WRITE cycle
    check("write_rf_wen", 32'(rf_wen), 32'(exp_wen));
    if (exp_wen) begin
      check("write_rf_waddr", 32'(rf_waddr), 32'(rd));
      check("write_rf_wdata", rf_wdata, exp_data);
    end
    check("write_pc_valid", 32'(pc_valid), 32'd0);
    check("write_in_ready", 32'(in_ready), 32'd0);

    for (int s = 0; s < stall; s++) begin
      @(negedge clock);  // COMMIT, IFU stalling
      check("stall_pc_valid", 32'(pc_valid), 32'd1);
      check("stall_pc_next", pc_next, exp_next);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_rf_wen", 32'(rf_wen), 32'd0);
      check("stall_trap_valid", 32'(trap_valid), 32'd0);
    end

    pc_ready = 1'b1;
    if (stall == 0) @(negedge clock);
    else #1;
    check("commit_pc_valid", 32'(pc_valid), 32'd1);
    check("commit_pc_next", pc_next, exp_next);
    check("commit_rf_wen", 32'(rf_wen), 32'd0);
    check("commit_trap_valid", 32'(trap_valid), 32'(err));
    if (err) begin
      check("commit_trap_epc", trap_epc, pc);
      check("commit_trap_tval", trap_tval, addr);
    end
    @(posedge clock);
    if (err) m_fault++;
    else     m_retire++;
    #1;
    pc_ready = 1'b0;
    @(negedge clock);
    check("after_retire_cnt", retire_cnt, m_retire);
    check("after_fault_cnt", fault_cnt, m_fault);
    check("after_in_ready", 32'(in_ready), 32'd1);
    check("after_pc_valid", 32'(pc_valid), 32'd0);
    check("after_trap_valid", 32'(trap_valid), 32'd0);
    $display("txn pc=%h rd=%0d wen=%0b err=%0b stall=%0d retire=%0d fault=%0d",
             pc, rd, exp_wen, err, stall, retire_cnt, fault_cnt);
  endtask

  initial begin
    int n_wen;
    reset = 1'b1; in_valid = 1'b0; pc_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clock);
    check("reset_rf_wen", 32'(rf_wen), 32'd0);
    check("reset_pc_valid", 32'(pc_valid), 32'd0);
    check("reset_pc_next", pc_next, 32'd0);
    check("reset_trap_valid", 32'(trap_valid), 32'd0);
    check("reset_retire_cnt", retire_cnt, 32'd0);
    check("reset_fault_cnt", fault_cnt, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // 1. ALU op
    run_instr(32'h8000_0000, 32'h8000_0004, 5'd5, 1'b1, 1'b0, 32'h1234, 32'h5555_0000,
              32'h0, 1'b0, 0);
    // 2. Load
    run_instr(32'h8000_0004, 32'h8000_0008, 5'd6, 1'b1, 1'b1, 32'hDEAD, 32'hFFFF_FF80,
              32'h2000_0000, 1'b0, 0);
    // 3. rd = x0
    run_instr(32'h8000_0008, 32'h8000_000C, 5'd0, 1'b1, 1'b0, 32'hCAFE, 32'h0,
              32'h0, 1'b0, 0);
    // 4. bus error -> access fault
    run_instr(32'h8000_0010, 32'h8000_0014, 5'd9, 1'b1, 1'b1, 32'h1, 32'h2,
              32'h1000_0003, 1'b1, 0);
    // 5. IFU stalls for 5 cycles
    run_instr(32'h8000_0014, 32'h8000_0100, 5'd10, 1'b1, 1'b0, 32'hABCD_0123, 32'h0,
              32'h0, 1'b0, 5);

    // 6a. back-to-back: 3 instructions in 9 cycles
    in_pc = 32'h8000_0020; in_next_pc = 32'h8000_0024; in_rd = 5'd3; in_rd_wen = 1'b1;
    in_is_load = 1'b0; in_alu_res = 32'h77; in_resp_err = 1'b0;
    in_valid = 1'b1; pc_ready = 1'b1;
    n_wen = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (rf_wen) n_wen++;
    end
    in_valid = 1'b0; pc_ready = 1'b0;
    m_retire += 3;
    check("b2b_rf_wen_count", 32'(n_wen), 32'd3);
    check("b2b_retire_cnt", retire_cnt, m_retire);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    $display("txn back-to-back wen_pulses=%0d retire=%0d", n_wen, retire_cnt);

    // 6b. reset during WRITE
    in_rd = 5'd7; in_rd_wen = 1'b1; in_resp_err = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("pre_reset_rf_wen", 32'(rf_wen), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_rf_wen", 32'(rf_wen), 32'd0);
    check("midreset_pc_valid", 32'(pc_valid), 32'd0);
    check("midreset_retire_cnt", retire_cnt, 32'd0);
    check("midreset_fault_cnt", fault_cnt, 32'd0);
    m_retire = 0; m_fault = 0;
    @(negedge clock);
    reset = 1'b0; pc_ready = 1'b1;
    @(negedge clock);
    check("postreset_in_ready", 32'(in_ready), 32'd1);
    check("postreset_rf_wen", 32'(rf_wen), 32'd0);
    check("postreset_retire_cnt", retire_cnt, 32'd0);
    pc_ready = 1'b0;
    $display("txn reset-in-write retire=%0d fault=%0d", retire_cnt, fault_cnt);

    // Randomized instructions against the model
    for (int k = 0; k < 30; k++) begin
      run_instr($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
